alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 154 +++++++++++++++
 tb/tb_alu_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle add/sub/logic/compare, iterative one-bit-per-cycle shifts.
// Result and flags are registered and held in DONE until the consumer takes them.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             sra_q, sra_d;

  logic             accept;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt;
  logic [SHW-1:0]   shamt;

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);

  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
  assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
  assign slt      = sub_full[WIDTH-1] ^ sub_ovf;
  assign shamt    = b[SHW-1:0];

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    cnt_d      = cnt_q;
    sra_d      = sra_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d    = StDone;
          carry_d    = 1'b0;
          overflow_d = 1'b0;
          unique case (op)
            3'b000: begin
              result_d   = add_full[WIDTH-1:0];
              carry_d    = add_full[WIDTH];
              overflow_d = add_ovf;
            end
            3'b001: begin
              result_d   = sub_full[WIDTH-1:0];
              carry_d    = ~sub_full[WIDTH];  // borrow is the inverted carry-out
              overflow_d = sub_ovf;
            end
            3'b010: result_d = a & b;
            3'b011: result_d = a | b;
            3'b100: result_d = a ^ b;
            3'b101: begin
              result_d   = {{(WIDTH-1){1'b0}}, slt};
              carry_d    = ~sub_full[WIDTH];
              overflow_d = sub_ovf;
            end
            3'b110, 3'b111: begin
              result_d = a;
              if (shamt != '0) begin
                cnt_d   = shamt;
                sra_d   = op[0];
                state_d = StShift;
              end
            end
            default: ;
          endcase
        end else if ((state_q == StDone) && out_ready) begin
          state_d = StIdle;
        end
      end
      StShift: begin
        if (sra_q) begin
          result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
          carry_d  = result_q[0];
        end else begin
          result_d = {result_q[WIDTH-2:0], 1'b0};
          carry_d  = result_q[WIDTH-1];
        end
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flags track whatever result is presented in DONE.
    if (state_d == StDone) begin
      zero_d     = (result_d == '0);
      negative_d = result_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      cnt_q      <= '0;
      sra_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      cnt_q      <= cnt_d;
      sra_q      <= sra_d;
    end
  end

  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign negative = negative_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: arithmetic reference model with a per-cycle compare process (WIDTH=32),
// directed vectors with literal expectations, plus a WIDTH=8 instance for boundary cases.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0, result;
  logic        carry, overflow, zero, negative;

  logic        in_valid8 = 1'b0, in_ready8, out_valid8;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, result8;
  logic        carry8, overflow8, zero8, negative8;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    longint r;
    bit     c;
    bit     v;
    int     acc;
    int     lat;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        c;
  } vec_t;

  vec_t vecs[15] = '{
    '{3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0},
    '{3'd1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0},
    '{3'd1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b1},
    '{3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1},
    '{3'd7, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0},
    '{3'd6, 32'h80000001, 32'h00000001, 32'h00000002, 1'b1},
    '{3'd6, 32'h00000001, 32'h00000025, 32'h00000020, 1'b0},
    '{3'd5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0},
    '{3'd5, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1},
    '{3'd5, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0},
    '{3'd2, 32'hF0F0F0F0, 32'hFFFF0000, 32'hF0F00000, 1'b0},
    '{3'd3, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 1'b0},
    '{3'd6, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0},
    '{3'd7, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0},
    '{3'd7, 32'h80000001, 32'h0000001F, 32'hFFFFFFFF, 1'b0}
  };

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry),
    .overflow(overflow), .zero(zero), .negative(negative)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8), .a(a8),
    .b(b8), .out_valid(out_valid8), .out_ready(1'b1), .result(result8), .carry(carry8),
    .overflow(overflow8), .zero(zero8), .negative(negative8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // Reference behaviour from plain integer arithmetic on w-bit two's complement values.
  function automatic void model(input int w, input logic [2:0] o, input longint ai,
                                input longint bi, output longint r, output bit c,
                                output bit v, output int lat);
    longint m, ua, ub, sa, sb, hi, lo;
    int n;
    m  = (longint'(1) << w) - 1;
    hi = m >> 1;
    lo = -hi - 1;
    ua = ai & m;
    ub = bi & m;
    sa = (((ua >> (w - 1)) & 1) != 0) ? ua - (m + 1) : ua;
    sb = (((ub >> (w - 1)) & 1) != 0) ? ub - (m + 1) : ub;
    n  = int'(ub % longint'(w));
    c = 1'b0; v = 1'b0; lat = 1; r = 0;
    case (o)
      3'd0: begin
        r = (ua + ub) & m;
        c = ((ua + ub) >> w) != 0;
        v = (sa + sb > hi) || (sa + sb < lo);
      end
      3'd1: begin
        r = (ua - ub) & m;
        c = ua < ub;
        v = (sa - sb > hi) || (sa - sb < lo);
      end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin
        r = (sa < sb) ? 1 : 0;
        c = ua < ub;
        v = (sa - sb > hi) || (sa - sb < lo);
      end
      3'd6: begin
        r = (ua << n) & m;
        c = (n > 0) && (((ua >> (w - n)) & 1) != 0);
        lat = n + 1;
      end
      default: begin
        r = (sa >>> n) & m;
        c = (n > 0) && (((ua >> (n - 1)) & 1) != 0);
        lat = n + 1;
      end
    endcase
  endfunction

  // Per-cycle comparison of the 32-bit DUT against the model's handshake and result view.
  always @(negedge clk) begin
    if (rst_n) begin
      bit   busy, ev, er;
      exp_t e;
      busy = q.size() > 0;
      ev   = busy && (cyc >= q[0].acc + q[0].lat - 1);
      er   = !busy || (ev && out_ready);
      check("out_valid", out_valid, ev);
      check("in_ready", in_ready, er);
      if (ev) begin
        check("result", result, q[0].r);
        check("carry", carry, q[0].c);
        check("overflow", overflow, q[0].v);
        check("zero", zero, q[0].r == 0);
        check("negative", negative, ((q[0].r >> 31) & 1) != 0);
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && er) begin
        model(32, op, longint'({32'b0, a}), longint'({32'b0, b}), e.r, e.c, e.v, e.lat);
        e.acc = cyc + 1;
        q.push_back(e);
      end
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r, input logic c, input string name);
    bit ok;
    op = o; a = x; b = y; in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) timeout({name, "_accept"});
    @(posedge clk); #1;
    // Scramble operands after acceptance; the DUT must have sampled them already.
    in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = out_valid;
    end
    if (!ok) timeout({name, "_result"});
    else begin
      check({name, "_lit_result"}, result, r);
      check({name, "_lit_carry"}, carry, c);
    end
    @(posedge clk); #1;
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] r, input string name);
    bit ok;
    longint mr;
    bit mc, mv;
    int ml;
    model(8, o, longint'(x), longint'(y), mr, mc, mv, ml);
    op8 = o; a8 = x; b8 = y; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = out_valid8;
    end
    if (!ok) timeout({name, "_w8"});
    else begin
      check({name, "_w8_lit"}, result8, r);
      check({name, "_w8_result"}, result8, mr);
      check({name, "_w8_carry"}, carry8, mc);
      check({name, "_w8_overflow"}, overflow8, mv);
      check({name, "_w8_zero"}, zero8, mr == 0);
      check({name, "_w8_negative"}, negative8, ((mr >> 7) & 1) != 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state; a request held during reset must not be taken.
    in_valid = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_flags", {carry, overflow, zero, negative}, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].c, $sformatf("vec%0d", i));

    // Backpressure: result held, no new request taken, then hand-over on the same edge.
    out_ready = 1'b0;
    op = 3'd0; a = 32'd5; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_result", result, 32'd12);
      check("bp_hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    op = 3'd4; a = 32'hF0F0F0F0; b = 32'hFFFF0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_xor_valid", out_valid, 1);
    check("bp_xor_result", result, 32'h0F0FF0F0);
    @(posedge clk); #1;

    // Back-to-back single-cycle ops.
    for (int i = 0; i < 8; i++) begin
      op = 3'(i % 6);
      a = 32'(i) * 32'h2468ACE1;
      b = ~a ^ (32'(i) << 3);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-shift abandons the operation.
    op = 3'd6; a = 32'h00000001; b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("midrst_result", result, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_flags", {carry, overflow, zero, negative}, 0);
    op = 3'd0; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    do_op(3'd0, 32'd1, 32'd1, 32'd2, 1'b0, "post_rst_add");

    run8(3'd0, 8'h7F, 8'h01, 8'h80, "add_ovf");
    run8(3'd1, 8'h80, 8'h01, 8'h7F, "sub_ovf");
    run8(3'd1, 8'h01, 8'h02, 8'hFF, "sub_borrow");
    run8(3'd7, 8'h80, 8'h0B, 8'hF0, "sra_mod");
    run8(3'd6, 8'h03, 8'h07, 8'h80, "sll_max");

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
